dmem_arbiter: RTL

//  Shares the single data-memory/peripheral bus between the pipeline MEM stage (CPU port) and an

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Data-memory bus arbiter: CPU MEM stage has priority, aux master gets a forced slot after MAX_WAIT lost cycles.
// Optional conflict counter enabled by defining MEMARB_PERF_CNT_EN.
module dmem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef MEMARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] conflict_cnt
`endif
);

  typedef enum logic {ST_ARB, ST_FORCE} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  if (MAX_WAIT < 1 || MAX_WAIT > 255 || CNT_W < 1) begin : g_bad_params
    $error("dmem_arbiter: MAX_WAIT must be 1..255 and CNT_W >= 1");
  end

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        aux_rvalid_q, aux_rvalid_d;
  logic [31:0] aux_rdata_q, aux_rdata_d;

  logic        cpu_req;
  logic        cpu_own;
  logic        aux_own;
  logic [7:0]  wait_inc;

  assign cpu_req = cpu_rd | cpu_wr;

  always_comb begin
    cpu_own    = 1'b0;
    aux_own    = 1'b0;
    cpu_stall  = 1'b0;
    state_d    = ST_ARB;
    wait_cnt_d = wait_cnt_q;
    wait_inc   = wait_cnt_q + 8'd1;
    if (reset) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_FORCE && aux_req) begin
      aux_own    = 1'b1;
      cpu_stall  = 1'b1;
      wait_cnt_d = '0;
    end else begin
      // An aborted FORCE slot (aux_req dropped) falls through to normal selection.
      if (cpu_req) begin
        cpu_own = 1'b1;
      end else if (aux_req) begin
        aux_own = 1'b1;
      end
      if (aux_req && !aux_own) begin
        if (wait_inc == WAIT_LIMIT) begin
          state_d    = ST_FORCE;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end else begin
        wait_cnt_d = '0;
      end
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (cpu_own) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      cpu_rdata = mem_rdata;
    end else if (aux_own) begin
      mem_rd    = ~aux_we;
      mem_wr    = aux_we;
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
    end
  end

  assign aux_gnt = aux_own;

  always_comb begin
    aux_rvalid_d = aux_own & ~aux_we;
    aux_rdata_d  = aux_rdata_q;
    if (aux_own && !aux_we) begin
      aux_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_ARB;
      wait_cnt_q   <= '0;
      aux_rvalid_q <= 1'b0;
      aux_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      aux_rvalid_q <= aux_rvalid_d;
      aux_rdata_q  <= aux_rdata_d;
    end
  end

  assign aux_rvalid = aux_rvalid_q;
  assign aux_rdata  = aux_rdata_q;

`ifdef MEMARB_PERF_CNT_EN
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  // Counts every cycle both masters want the bus, FORCE cycles included; sticks at all-ones.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (aux_req && cpu_req && !(&conflict_cnt_q)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
